exhaustive_error_monitor: RTL and testbench

//   Synthesizable successor to the per-partition exhaustive testbench flow.

---
 rtl/exhaustive_error_monitor.sv | 112 +++++++++++
 tb/tb_exhaustive_error_monitor.sv | 112 +++++++++++
 2 files changed

// File: rtl/exhaustive_error_monitor.sv
// exhaustive_error_monitor: sweeps all 2**IN_W vectors and accumulates exact-vs-approximate error metrics; EMON_HAMMING_EN adds sum_bit_err
module exhaustive_error_monitor #(
  parameter int IN_W   = 7,
  parameter int OUT_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [IN_W-1:0]       stim,
  input  logic [OUT_W-1:0]      ref_po,
  input  logic [OUT_W-1:0]      apx_po,
  output logic                  busy,
  output logic                  done,
  output logic [IN_W:0]         err_count,
  output logic [IN_W+OUT_W-1:0] sum_abs_err,
  output logic [OUT_W-1:0]      max_abs_err
`ifdef EMON_HAMMING_EN
  ,
  output logic [IN_W+$clog2(OUT_W+1)-1:0] sum_bit_err
`endif
);
  localparam int SW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IN_W-1:0] stim_q, stim_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [IN_W:0] err_q, err_d;
  logic [IN_W+OUT_W-1:0] sum_q, sum_d;
  logic [OUT_W-1:0] max_q, max_d, d;
  logic signed [OUT_W:0] diff, mag;
  assign diff = signed'({1'b0, ref_po}) - signed'({1'b0, apx_po});
  assign mag  = diff[OUT_W] ? -diff : diff;
  assign d    = mag[OUT_W-1:0];
`ifdef EMON_HAMMING_EN
  localparam int PW = $clog2(OUT_W + 1);
  logic [IN_W+PW-1:0] bit_q, bit_d;
  logic [PW-1:0] pc;
  always_comb begin
    pc = '0;
    for (int i = 0; i < OUT_W; i++) pc = pc + PW'(ref_po[i] ^ apx_po[i]);
  end
`endif
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum_d   = sum_q;
    max_d   = max_q;
`ifdef EMON_HAMMING_EN
    bit_d   = bit_q;
`endif
    if (state_q != RUN && start) begin
      state_d = RUN;
      stim_d  = '0;
      cnt_d   = SW'(SETTLE);
      err_d   = '0;
      sum_d   = '0;
      max_d   = '0;
`ifdef EMON_HAMMING_EN
      bit_d   = '0;
`endif
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - SW'(1);
      end else begin
        err_d   = err_q + (IN_W+1)'(d != '0);
        sum_d   = sum_q + (IN_W+OUT_W)'(d);
        max_d   = d > max_q ? d : max_q;
        stim_d  = stim_q + IN_W'(1);
        cnt_d   = SW'(SETTLE);
        state_d = &stim_q ? DONE : RUN;
`ifdef EMON_HAMMING_EN
        bit_d   = bit_q + (IN_W+PW)'(pc);
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
`ifdef EMON_HAMMING_EN
      bit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
`ifdef EMON_HAMMING_EN
      bit_q   <= bit_d;
`endif
    end
  end
  assign stim        = stim_q;
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
  assign err_count   = err_q;
  assign sum_abs_err = sum_q;
  assign max_abs_err = max_q;
`ifdef EMON_HAMMING_EN
  assign sum_bit_err = bit_q;
`endif
endmodule

// File: tb/tb_exhaustive_error_monitor.sv
// tb_exhaustive_error_monitor: randomized sweeps checked against a per-vector error-metric model
module tb_exhaustive_error_monitor;
  logic clk = 0, rst = 1, start = 0;
  logic [6:0] stim;
  logic [3:0] ref_po, apx_po;
  logic busy, done;
  logic [7:0] err_count;
  logic [10:0] sum_abs_err;
  logic [3:0] max_abs_err;
  logic [3:0] lut [128];
  int n_chk = 0, n_err = 0;
  int e_err, e_sum, e_max, e_bit;
`ifdef EMON_HAMMING_EN
  logic [9:0] sum_bit_err;
`endif
  always #5 clk = ~clk;
  assign ref_po = stim[3:0];
  assign apx_po = lut[stim];
  exhaustive_error_monitor #(.IN_W(7), .OUT_W(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .ref_po(ref_po), .apx_po(apx_po),
    .busy(busy), .done(done), .err_count(err_count), .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err)
`ifdef EMON_HAMMING_EN
    , .sum_bit_err(sum_bit_err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model();
    e_err = 0; e_sum = 0; e_max = 0; e_bit = 0;
    for (int v = 0; v < 128; v++) begin
      int r, a, dd;
      r = v % 16;
      a = int'(lut[v]);
      dd = r > a ? r - a : a - r;
      e_err += dd != 0;
      e_sum += dd;
      e_max = dd > e_max ? dd : e_max;
      e_bit += $countones(4'(r) ^ 4'(a));
    end
  endtask
  task automatic check_final(input string tag);
    chk({tag, "_err"}, 32'(err_count), e_err);
    chk({tag, "_sum"}, 32'(sum_abs_err), e_sum);
    chk({tag, "_max"}, 32'(max_abs_err), e_max);
`ifdef EMON_HAMMING_EN
    chk({tag, "_bit"}, 32'(sum_bit_err), e_bit);
`endif
  endtask
  task automatic sweep(input string tag, input bit poke);
    int cyc;
    model();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk({tag, "_e0busy"}, 32'(busy), 1);
    chk({tag, "_e0done"}, 32'(done), 0);
    chk({tag, "_e0acc"}, 32'({err_count, sum_abs_err, max_abs_err, stim}), 0);
    cyc = 0;
    while (!done && cyc < 400) begin
      start = poke && (cyc == 9 || cyc == 99);
      @(posedge clk); #1 cyc++;
    end
    start = 0;
    chk({tag, "_len"}, 32'(cyc), 256);
    chk({tag, "_stim"}, 32'(stim), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    check_final(tag);
    repeat (3) @(posedge clk);
    #1 check_final({tag, "_hold"});
    chk({tag, "_holddone"}, 32'(done), 1);
  endtask
  initial begin
    for (int i = 0; i < 128; i++) lut[i] = 4'(i);
    repeat (2) @(posedge clk);
    #1 chk("rst_out", 32'({stim, busy, done, err_count, sum_abs_err, max_abs_err}), 0);
    start = 1;
    @(posedge clk); #1 start = 0;
    chk("rst_wins_busy", 32'(busy), 0);
    rst = 0;
    sweep("exact", 0);
    for (int i = 0; i < 128; i++) lut[i] = 4'(i) ^ 4'b0001;
    sweep("xor1", 0);
    chk("xor1_lit", 32'({err_count, sum_abs_err, max_abs_err}), {8'd128, 11'd128, 4'd1});
    for (int i = 0; i < 128; i++) lut[i] = 4'(0);
    sweep("zero", 1);
    chk("zero_lit", 32'({err_count, sum_abs_err, max_abs_err}), {8'd120, 11'd960, 4'd15});
    for (int i = 0; i < 128; i++) lut[i] = 4'(i) ^ 4'b0001;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("done_clr", 32'({done, err_count, sum_abs_err, max_abs_err}), 0);
    repeat (49) @(posedge clk);
    #1 chk("mid_busy", 32'(busy), 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("midrst_out", 32'({stim, busy, done, err_count, sum_abs_err, max_abs_err}), 0);
    @(posedge clk); #1 chk("midrst_idle", 32'({busy, done}), 0);
    sweep("after_rst", 0);
    for (int i = 0; i < 128; i++) lut[i] = 4'(i) ^ 4'b0011;
    sweep("xor3", 0);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 128; i++) lut[i] = 4'($urandom_range(0, 15));
      sweep($sformatf("rand%0d", s), s[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
